// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM generator / capture pair: default counter
// width, default period (one generator tick period) and the capture FSM
// state encoding.
package pwm_pkg;

    localparam int CNT_W_DEF      = 32;
    localparam int MAX_PERIOD_DEF = 1000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } cap_state_t;

endpackage : pwm_pkg

// File: rtl/pwm_capture_if.sv
// Signal bundle between a PWM capture block and its surroundings.
// master: drives the enable and the PWM line, consumes the measurements.
// slave:  the capture block itself.
interface pwm_capture_if #(
    parameter int CNT_W = pwm_pkg::CNT_W_DEF
);

    logic             en;
    logic             pwm_in;
    logic [CNT_W-1:0] width;
    logic [CNT_W-1:0] period;
    logic             valid;
    logic             stuck_hi;
    logic             stuck_lo;

    modport master (
        output en, pwm_in,
        input  width, period, valid, stuck_hi, stuck_lo
    );

    modport slave (
        input  en, pwm_in,
        output width, period, valid, stuck_hi, stuck_lo
    );

endinterface : pwm_capture_if

// File: rtl/pwm_in_sync.sv
// Input conditioning for the PWM capture block: multi-flop synchronizer,
// optional glitch filter (built only when PWM_CAPTURE_DEGLITCH_EN is
// defined) and rise/fall edge detection.
// Both edges pass through the same pipeline, so high and period lengths
// seen downstream equal those on the pin.
// After reset, edge detection stays muted until the pipeline holds the
// real pin level, so a line that is already high is not mistaken for a
// rising edge.
module pwm_in_sync #(
    parameter int SYNC_STAGES  = 2,
    parameter int DEGLITCH_LEN = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pwm_in,
    output logic lvl,
    output logic rise,
    output logic fall
);

    localparam int              PRIME_LEN = SYNC_STAGES + 2;
    localparam int              PRIME_W   = $clog2(PRIME_LEN + 1);
    localparam logic [PRIME_W-1:0] PRIME_MAX = PRIME_W'(PRIME_LEN);

    if (SYNC_STAGES < 2 || DEGLITCH_LEN < 1) begin : g_param_check
        $error("pwm_in_sync: SYNC_STAGES must be >= 2 and DEGLITCH_LEN >= 1");
    end

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_out;
    logic [PRIME_W-1:0]     prime_cnt;
    logic                   primed;
    logic                   lvl_d;

    assign sync_out = sync_q[SYNC_STAGES-1];
    assign primed   = (prime_cnt == PRIME_MAX);

    // Synchronizer chain: shift the asynchronous pin in every cycle.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values; blocking here would collapse the chain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pwm_in};
        end
    end

    // Count the cycles needed for the pipeline to carry the real pin level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prime_cnt <= '0;
        end else if (!primed) begin
            prime_cnt <= prime_cnt + PRIME_W'(1);
        end
    end

`ifdef PWM_CAPTURE_DEGLITCH_EN
    localparam int                 DG_W    = $clog2(DEGLITCH_LEN + 1);
    localparam logic [DG_W-1:0]    DG_LAST = DG_W'(DEGLITCH_LEN - 1);

    logic            lvl_f;
    logic [DG_W-1:0] dg_cnt;

    // Glitch filter: follow the synced input only after it has disagreed
    // with the filtered level for DEGLITCH_LEN consecutive cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lvl_f  <= 1'b0;
            dg_cnt <= '0;
        end else if (!primed) begin
            lvl_f  <= sync_out;
            dg_cnt <= '0;
        end else if (sync_out != lvl_f) begin
            if (dg_cnt == DG_LAST) begin
                lvl_f  <= sync_out;
                dg_cnt <= '0;
            end else begin
                dg_cnt <= dg_cnt + DG_W'(1);
            end
        end else begin
            dg_cnt <= '0;
        end
    end

    assign lvl = lvl_f;
`else
    assign lvl = sync_out;
`endif

    // Delayed copy of the level for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lvl_d <= 1'b0;
        end else begin
            lvl_d <= lvl;
        end
    end

    assign rise = primed &  lvl & ~lvl_d;
    assign fall = primed & ~lvl &  lvl_d;

endmodule : pwm_in_sync

// File: rtl/pwm_capture.sv
// PWM capture: measures the high time and period of an incoming PWM line in
// clk cycles, rise to rise. A line with no edge for MAX_PERIOD cycles
// reports a timeout (stuck_hi / stuck_lo) and repeats it every MAX_PERIOD
// cycles while the line stays put.
// Optional glitch filter: define PWM_CAPTURE_DEGLITCH_EN.
module pwm_capture
    import pwm_pkg::*;
#(
    parameter int CNT_W        = CNT_W_DEF,
    parameter int MAX_PERIOD   = MAX_PERIOD_DEF,
    parameter int SYNC_STAGES  = 2,
    parameter int DEGLITCH_LEN = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    pwm_capture_if.slave  cap
);

    localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] MAX_P = CNT_W'(MAX_PERIOD);

    logic lvl;
    logic rise;
    logic fall;
    logic edge_any;
    logic timeout;
    logic load_meas;
    logic load_to;

    cap_state_t       state_q,   state_d;
    logic [CNT_W-1:0] cnt_hi_q,  cnt_hi_d;
    logic [CNT_W-1:0] cnt_per_q, cnt_per_d;
    logic [CNT_W-1:0] idle_q,    idle_d;

    logic [CNT_W-1:0] width_q;
    logic [CNT_W-1:0] period_q;
    logic             valid_q;
    logic             stuck_hi_q;
    logic             stuck_lo_q;

    pwm_in_sync #(
        .SYNC_STAGES  (SYNC_STAGES),
        .DEGLITCH_LEN (DEGLITCH_LEN)
    ) u_sync (
        .clk    (clk),
        .rst_n  (rst_n),
        .pwm_in (cap.pwm_in),
        .lvl    (lvl),
        .rise   (rise),
        .fall   (fall)
    );

    assign edge_any = rise | fall;
    // A rise (or fall) on the timeout cycle wins and keeps the measurement.
    assign timeout  = cap.en & ~edge_any & (idle_q == MAX_P - ONE);

    // State, measurement counters and idle counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_hi_q  <= '0;
            cnt_per_q <= '0;
            idle_q    <= '0;
        end else begin
            state_q   <= state_d;
            cnt_hi_q  <= cnt_hi_d;
            cnt_per_q <= cnt_per_d;
            idle_q    <= idle_d;
        end
    end

    // Next state, counter updates and result-load requests.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a signal unassigned and no latch is inferred.
        state_d   = state_q;
        cnt_hi_d  = cnt_hi_q;
        cnt_per_d = cnt_per_q;
        idle_d    = idle_q + ONE;
        load_meas = 1'b0;
        load_to   = 1'b0;

        if (!cap.en) begin
            state_d   = IDLE;
            cnt_hi_d  = '0;
            cnt_per_d = '0;
            idle_d    = '0;
        end else begin
            if (edge_any) begin
                idle_d = '0;
            end

            unique case (state_q)
                IDLE: begin
                    if (rise) begin
                        state_d   = HIGH;
                        cnt_hi_d  = ONE;
                        cnt_per_d = ONE;
                    end
                end
                HIGH: begin
                    if (fall) begin
                        state_d   = LOW;
                        cnt_per_d = cnt_per_q + ONE;
                    end else begin
                        cnt_hi_d  = cnt_hi_q + ONE;
                        cnt_per_d = cnt_per_q + ONE;
                    end
                end
                LOW: begin
                    if (rise) begin
                        load_meas = 1'b1;
                        state_d   = HIGH;
                        cnt_hi_d  = ONE;
                        cnt_per_d = ONE;
                    end else begin
                        cnt_per_d = cnt_per_q + ONE;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase

            if (timeout) begin
                load_to   = 1'b1;
                state_d   = IDLE;
                cnt_hi_d  = '0;
                cnt_per_d = '0;
                idle_d    = '0;
            end
        end
    end

    // Result registers: load a measurement or a timeout report, strobe valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            width_q    <= '0;
            period_q   <= '0;
            valid_q    <= 1'b0;
            stuck_hi_q <= 1'b0;
            stuck_lo_q <= 1'b0;
        end else begin
            valid_q <= load_meas | load_to;
            if (load_meas) begin
                width_q    <= cnt_hi_q;
                period_q   <= cnt_per_q;
                stuck_hi_q <= 1'b0;
                stuck_lo_q <= 1'b0;
            end else if (load_to) begin
                width_q    <= lvl ? MAX_P : '0;
                period_q   <= MAX_P;
                stuck_hi_q <= lvl;
                stuck_lo_q <= ~lvl;
            end
        end
    end

    assign cap.width    = width_q;
    assign cap.period   = period_q;
    assign cap.valid    = valid_q;
    assign cap.stuck_hi = stuck_hi_q;
    assign cap.stuck_lo = stuck_lo_q;

endmodule : pwm_capture
